// File: rtl/fp32_div_sqrt_requester_pkg.sv
// Shared types for the FP32 divide/sqrt request path.
// Used by the requester and the iterative divider it talks to.
package fp32_div_sqrt_requester_pkg;

  typedef struct packed {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        is_divide;
  } fdiv_sqrt_req_path_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ISSUE,
    PH_WAIT,
    PH_DRAIN,
    PH_DONE
  } fdiv_sqrt_req_phase_t;

endpackage

// File: rtl/fp32_div_sqrt_requester.sv
// Initiator side of the FP32 div/sqrt req/finished handshake.
// Holds one op in flight, returns its result with its tag.
module fp32_div_sqrt_requester
  import fp32_div_sqrt_requester_pkg::*;
#(
  parameter int TAG_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_lhs,
  input  logic [31:0]          in_rhs,
  input  logic                 in_is_divide,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 div_req,
  output logic [31:0]          div_lhs,
  output logic [31:0]          div_rhs,
  output logic                 div_is_divide,
  input  logic                 div_finished,
  input  logic [31:0]          div_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  fdiv_sqrt_req_phase_t state, state_n;
  fdiv_sqrt_req_path_t  op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [31:0]          result_q;
  logic [CW-1:0]        cnt;
  logic                 err_q;

  logic accept;
  logic timeout;
  logic cap;
  logic clr_cnt;
  logic count_en;
  logic set_err;

  // flush masks ready so a flushed cycle never looks like a handshake
  assign in_ready = ((state == PH_IDLE) |
                     ((state == PH_DONE) & out_ready)) & ~flush;
  assign accept   = in_valid & in_ready;
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES));
  assign count_en = ((state == PH_WAIT) | (state == PH_DRAIN)) & ~timeout;

  assign div_req       = (state == PH_ISSUE);
  assign div_lhs       = op_q.lhs;
  assign div_rhs       = op_q.rhs;
  assign div_is_divide = op_q.is_divide;
  assign out_valid     = (state == PH_DONE);
  assign out_result    = result_q;
  assign out_tag       = tag_q;
  assign err_timeout   = err_q;

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    clr_cnt = 1'b0;
    set_err = 1'b0;
    unique case (state)
      PH_IDLE: begin
        if (accept) state_n = PH_ISSUE;
      end
      PH_ISSUE: begin
        // finished is still the idle level here; req cannot be retracted
        clr_cnt = 1'b1;
        state_n = flush ? PH_DRAIN : PH_WAIT;
      end
      PH_WAIT: begin
        if (div_finished) begin
          cap     = ~flush;
          state_n = flush ? PH_IDLE : PH_DONE;
        end else if (flush) begin
          clr_cnt = 1'b1;
          state_n = PH_DRAIN;
        end else if (timeout) begin
          set_err = 1'b1;
          state_n = PH_IDLE;
        end
      end
      PH_DRAIN: begin
        if (div_finished) begin
          state_n = PH_IDLE;
        end else if (timeout) begin
          set_err = 1'b1;
          state_n = PH_IDLE;
        end
      end
      PH_DONE: begin
        if (flush)          state_n = PH_IDLE;
        else if (accept)    state_n = PH_ISSUE;
        else if (out_ready) state_n = PH_IDLE;
      end
      default: state_n = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PH_IDLE;
      op_q     <= '0;
      tag_q    <= '0;
      result_q <= '0;
      cnt      <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q.lhs       <= in_lhs;
        op_q.rhs       <= in_rhs;
        op_q.is_divide <= in_is_divide;
        tag_q          <= in_tag;
      end
      if (cap)           result_q <= div_result;
      if (clr_cnt)       cnt      <= '0;
      else if (count_en) cnt      <= cnt + CW'(1);
      if (set_err)       err_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_div_sqrt_requester.sv
// Bench for fp32_div_sqrt_requester with a behavioural divider model.
// Results are checked against a queue of expected (result, tag) pairs.
module tb_fp32_div_sqrt_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_lhs = '0;
  logic [31:0] in_rhs = '0;
  logic        in_is_divide = 1'b0;
  logic [5:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        div_req;
  logic [31:0] div_lhs;
  logic [31:0] div_rhs;
  logic        div_is_divide;
  logic        div_finished;
  logic [31:0] div_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic        err_timeout;

  fp32_div_sqrt_requester #(.TAG_WIDTH(6), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lhs(in_lhs), .in_rhs(in_rhs),
    .in_is_divide(in_is_divide), .in_tag(in_tag),
    .flush(flush),
    .div_req(div_req), .div_lhs(div_lhs), .div_rhs(div_rhs),
    .div_is_divide(div_is_divide),
    .div_finished(div_finished), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmodel(input logic [31:0] l, r,
                                         input logic d);
    if (d && l == 32'h40C00000 && r == 32'h40000000) return 32'h40400000;
    if (!d && l == 32'h40800000) return 32'h40000000;
    if (!d && l == 32'hBF800000) return 32'h7FC00000;
    return l ^ {r[15:0], r[31:16]} ^ (d ? 32'h0 : 32'h5A5A5A5A);
  endfunction

  // divider: finished low from the cycle after req until T+17/T+16
  logic        stall = 1'b0;
  int          rem = 0;
  logic [31:0] res_q = '0;
  always @(posedge clk) begin
    if (rst) begin
      rem   <= 0;
      res_q <= '0;
    end else if (div_req) begin
      rem   <= div_is_divide ? 15 : 14;
      res_q <= fmodel(div_lhs, div_rhs, div_is_divide);
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end
  assign div_finished = !stall && rem == 0;
  assign div_result   = div_finished ? res_q : 32'hDEADBEEF;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out_valid cyc=%0d result=%h tag=%0d required none",
                 cyc, out_result, out_tag);
      end else if (out_ready) begin
        e = q.pop_front();
        n_cmp += 2;
        if (out_result !== e.res) begin
          n_err++;
          $display("FAIL sb_result got=%h exp=%h", out_result, e.res);
        end
        if (out_tag !== e.tag) begin
          n_err++;
          $display("FAIL sb_tag got=%0d exp=%0d", out_tag, e.tag);
        end
      end
    end
  end

  task automatic push(input logic [31:0] r, input logic [5:0] t);
    exp_t e;
    e.res = r;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] l, r, input logic d,
                      input logic [5:0] t, output int acc);
    acc = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_lhs = l; in_rhs = r;
    in_is_divide = d; in_tag = t;
    for (int i = 0; i < 100 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_accept got=no_ready exp=accept tag=%0d", t);
    end
  endtask

  task automatic watch(input int n, output int req_cyc, output int req_n,
                       output int ov_cyc, output int ov_n,
                       output logic [64:0] ops);
    req_cyc = -1; req_n = 0; ov_cyc = -1; ov_n = 0; ops = '0;
    repeat (n) begin
      @(negedge clk);
      if (div_req) begin
        if (req_cyc < 0) begin
          req_cyc = cyc;
          ops = {div_lhs, div_rhs, div_is_divide};
        end
        req_n++;
      end
      if (out_valid) begin
        if (ov_cyc < 0) ov_cyc = cyc;
        ov_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (div_req !== 1'b0)    begin n_err++; $display("FAIL rst_div_req got=%b exp=0", div_req); end
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
    if (out_result !== 32'h0) begin n_err++; $display("FAIL rst_result got=%h exp=0", out_result); end
    if (out_tag !== 6'h0)    begin n_err++; $display("FAIL rst_tag got=%0d exp=0", out_tag); end
    if (div_lhs !== 32'h0)   begin n_err++; $display("FAIL rst_div_lhs got=%h exp=0", div_lhs); end
  endtask

  task automatic test_op(input logic [31:0] l, r, input logic d,
                         input logic [5:0] t, input int lat, input string nm);
    int acc, rc, rn, oc, on;
    logic [64:0] ops;
    push(fmodel(l, r, d), t);
    send(l, r, d, t, acc);
    watch(25, rc, rn, oc, on, ops);
    n_cmp += 5;
    if (rc !== acc + 1) begin n_err++; $display("FAIL %s_req_cyc got=%0d exp=%0d", nm, rc, acc + 1); end
    if (rn !== 1)       begin n_err++; $display("FAIL %s_req_count got=%0d exp=1", nm, rn); end
    if (ops !== {l, r, d}) begin n_err++; $display("FAIL %s_req_ops got=%h exp=%h", nm, ops, {l, r, d}); end
    if (oc !== acc + lat) begin n_err++; $display("FAIL %s_ov_cyc got=%0d exp=%0d", nm, oc, acc + lat); end
    if (on !== 1)       begin n_err++; $display("FAIL %s_ov_count got=%0d exp=1", nm, on); end
  endtask

  task automatic test_divide();
    test_op(32'h40C00000, 32'h40000000, 1'b1, 6'd5, 18, "div");
  endtask

  task automatic test_sqrt();
    test_op(32'h40800000, 32'h0, 1'b0, 6'd9, 17, "sqrt4");
    test_op(32'hBF800000, 32'h0, 1'b0, 6'd10, 17, "sqrtneg");
  endtask

  task automatic test_back_to_back();
    int acc, rc, rn, oc, on, tb;
    logic [64:0] ops;
    logic [31:0] ea;
    ea = fmodel(32'h3F800000, 32'h40400000, 1'b1);
    out_ready = 1'b0;
    push(ea, 6'd12);
    send(32'h3F800000, 32'h40400000, 1'b1, 6'd12, acc);
    watch(18, rc, rn, oc, on, ops);
    n_cmp++;
    if (oc !== acc + 18) begin n_err++; $display("FAIL b2b_first_ov got=%0d exp=%0d", oc, acc + 18); end
    repeat (10) begin
      @(negedge clk);
      n_cmp += 3;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
      if (out_result !== ea)  begin n_err++; $display("FAIL hold_result got=%h exp=%h", out_result, ea); end
      if (out_tag !== 6'd12)  begin n_err++; $display("FAIL hold_tag got=%0d exp=12", out_tag); end
    end
    push(fmodel(32'h41200000, 32'h40A00000, 1'b1), 6'd13);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_lhs = 32'h41200000; in_rhs = 32'h40A00000;
    in_is_divide = 1'b1; in_tag = 6'd13;
    @(negedge clk);
    tb = cyc;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    watch(25, rc, rn, oc, on, ops);
    n_cmp += 3;
    if (rc !== tb + 1)  begin n_err++; $display("FAIL b2b_req got=%0d exp=%0d", rc, tb + 1); end
    if (oc !== tb + 18) begin n_err++; $display("FAIL b2b_ov got=%0d exp=%0d", oc, tb + 18); end
    if (on !== 1)       begin n_err++; $display("FAIL b2b_ov_count got=%0d exp=1", on); end
  endtask

  task automatic test_flush_drain();
    int acc, ovn;
    send(32'h40E00000, 32'h40000000, 1'b1, 6'd20, acc);
    while (cyc < acc + 5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    ovn = 0;
    repeat (13) begin
      @(negedge clk);
      if (out_valid) ovn++;
      n_cmp++;
      if (cyc <= acc + 17) begin
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL drain_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      end else begin
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_exit cyc=%0d got=%b exp=1", cyc, in_ready); end
      end
    end
    n_cmp++;
    if (ovn !== 0) begin n_err++; $display("FAIL drain_out_valid got=%0d exp=0", ovn); end
    test_op(32'h40000000, 32'h3F000000, 1'b1, 6'd21, 18, "post_flush");
  endtask

  task automatic test_flush_corner();
    int acc, rc, rn, oc, on;
    logic [64:0] ops;
    send(32'h40400000, 32'h40000000, 1'b1, 6'd30, acc);
    while (cyc < acc + 17) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL fin_flush_idle got=%b exp=1", in_ready); end
    watch(5, rc, rn, oc, on, ops);
    n_cmp++;
    if (on !== 0) begin n_err++; $display("FAIL fin_flush_ov got=%0d exp=0", on); end
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1;
    in_lhs = 32'h3F800000; in_rhs = 32'h3F800000;
    in_is_divide = 1'b1; in_tag = 6'd31;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    watch(20, rc, rn, oc, on, ops);
    n_cmp += 2;
    if (rn !== 0) begin n_err++; $display("FAIL idle_flush_req got=%0d exp=0", rn); end
    if (on !== 0) begin n_err++; $display("FAIL idle_flush_ov got=%0d exp=0", on); end
  endtask

  task automatic test_timeout();
    int acc, ec;
    stall = 1'b1;
    send(32'h40C00000, 32'h40000000, 1'b1, 6'd40, acc);
    while (cyc < acc + 60) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_early got=%b exp=0", err_timeout); end
    ec = -1;
    for (int i = 0; i < 20 && ec < 0; i++) begin
      @(negedge clk);
      if (err_timeout) ec = cyc;
    end
    n_cmp += 3;
    if (ec !== acc + 67)   begin n_err++; $display("FAIL to_cyc got=%0d exp=%0d", ec, acc + 67); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL to_idle got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL to_out_valid got=%b exp=0", out_valid); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
    stall = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_rst_clear got=%b exp=0", err_timeout); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divide();
    test_sqrt();
    test_back_to_back();
    test_flush_drain();
    test_flush_corner();
    test_timeout();
    n_cmp++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL sb_leftover got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
